alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Multi-cycle controller that executes 6502 arithmetic, logic, shift, compare and read-modify-write-combo operations on the shared combinational ALU. It owns the processor status flags N, V, Z and C, and sequences one or two ALU passes per request. Requests come from the CPU decode stage over a valid/ready handshake; results return over a valid/ready handshake.

Parameters:
MODE_ADD, 5'd0, ALU mode code for add
MODE_AND, 5'd2, ALU mode code for AND
MODE_OR, 5'd3, ALU mode code for OR
MODE_EOR, 5'd4, ALU mode code for XOR
MODE_SR, 5'd5, ALU mode code for rotate-right through carry_in

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
req_valid  in  1  request valid
req_ready  out  1  high only in IDLE
req_op  in  4  0 ADC,1 SBC,2 AND,3 ORA,4 EOR,5 CMP,6 ASL,7 LSR,8 ROL,9 ROR,A INC,B DEC,C BIT,D DCP,E ISC,F RLA
req_a  in  8  accumulator / unary operand
req_b  in  8  second operand / memory operand for D-F
rsp_valid  out  1  result valid
rsp_ready  in  1  result accepted
rsp_data  out  8  final result (accumulator value)
rsp_wb  out  8  memory write-back value (pass-1 result for D-F, else = rsp_data)
flag_load  in  1  load flags from flag_in (PLP/SEC/CLC etc.)
flag_in  in  4  {N,V,Z,C}
flags  out  4  {N,V,Z,C}
alu_a, alu_b  out  8 each  ALU operands
alu_mode  out  5  ALU mode
alu_carry_in  out  1  ALU carry in
alu_out  in  8  ALU result
alu_carry_out  in  1  ALU bit 8

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values: state IDLE, flags 4'b0000, rsp_valid 0, rsp_data 0, rsp_wb 0, and all internal operand registers 0.
- ALU drive in IDLE and DONE: alu_a 0, alu_b 0, alu_mode MODE_AND, alu_carry_in 0.
- All ALU inputs come from registers only; no combinational path from req_* to alu_*.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch op, a, b and the current C into registers, then go to P1.
  - P1: drive pass 1 and sample alu_out/alu_carry_out at the end of the cycle. Ops 0-C go to DONE; ops D-F go to P2.
  - P2: drive pass 2 using a and the P1 result m. Go to DONE.
  - DONE: rsp_valid=1 and the flags are already updated. Hold until rsp_ready, then go to IDLE.
- Latency: rsp_valid rises 2 edges after the accept edge for single-pass ops and 3 edges for two-pass ops.
- Z and N come from alu_out[7:0] only. alu_carry_out is used only where C is listed below.
- V is computed internally: V = (x7==y7) && (r7!=x7), where x and y are the ALU operands actually driven.
- Pass mappings (SUB mode is never used):
  - ADC: ADD a+b+C. Updates NVZC.
  - SBC: ADD a+~b+C. Updates NVZC.
  - AND/ORA/EOR: NZ only.
  - CMP: ADD a+~b+1. Updates NZC. rsp_data=a.
  - ASL: ADD a+a, carry_in 0. Updates NZC.
  - ROL: ADD a+a+C. Updates NZC.
  - LSR: SR a, carry_in 0. Updates NZC (C=a[0]).
  - ROR: SR a, carry_in C. Updates NZC.
  - INC: ADD a+1. Updates NZ.
  - DEC: ADD a+0xFF. Updates NZ.
  - BIT: AND a&b. Z from result, N=b[7], V=b[6]. rsp_data=a.
  - DCP: P1 = b+0xFF gives m; P2 = CMP a vs m. rsp_wb=m, rsp_data=a.
  - ISC: P1 = b+1 gives m; P2 = SBC a-m using the latched C. Updates NVZC.
  - RLA: P1 = ROL b gives m, and C comes from P1; P2 = a&m updates NZ.
- Flag write is a single update on the P1→DONE or P2→DONE edge. Flags not listed for an op are unchanged.
- flag_load:
  - Honoured only in IDLE, and only in a cycle where no request is accepted. If flag_load and req_valid are both high in IDLE, flag_load wins and req_ready is forced to 0 that cycle.
  - Ignored in P1, P2 and DONE.
- Back-to-back requests: the earliest accept is the cycle after rsp_valid&&rsp_ready. No bypass.
- rsp_data, rsp_wb and flags hold stable while rsp_valid=1 and rsp_ready=0.
- Asserting reset_n low in any state returns immediately to the reset values. A partial P1 result is never committed to flags.

Test Plan:
- ADC a=0x50 b=0x50 C=0 → rsp_data 0xA0, flags N1 V1 Z0 C0, rsp_valid exactly 2 edges after accept.
- ADC a=0x80 b=0x80 C=0 → 0x00, N0 V1 Z1 C1. Checks that Z ignores bit 8.
- CMP a=0x10 b=0x10 → rsp_data 0x10, N0 Z1 C1, V unchanged. Then CMP a=0x10 b=0x20 → N1 Z0 C0.
- ROR a=0x01 C=1 → 0x80, N1 Z0 C1. LSR a=0x01 → 0x00, Z1 C1.
- DCP a=0x05 b=0x06 → rsp_wb 0x05, rsp_data 0x05, Z1 C1, latency 3. ISC a=0x10 b=0x0F C=1 → wb 0x10, data 0x00, Z1 C1.
- Hold rsp_ready=0 for 4 cycles → outputs stable and req_ready 0. flag_load with flag_in=4'b1111 mid-op is ignored. Pull reset_n low in P2 → IDLE, flags 0, rsp_valid 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller for the 6502 arithmetic/logic/shift/
// compare/RMW-combo operations on an external combinational ALU. It owns the
// N,V,Z,C status flags and runs one ALU pass (ops 0-C) or two passes (ops D-F).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. Once raised, valid and the payload stay stable until that edge.
// The request side accepts only in IDLE, and not while flag_load is high.
module alu_sequencer #(
   parameter logic [4:0] MODE_ADD = 5'd0,
   parameter logic [4:0] MODE_AND = 5'd2,
   parameter logic [4:0] MODE_OR  = 5'd3,
   parameter logic [4:0] MODE_EOR = 5'd4,
   parameter logic [4:0] MODE_SR  = 5'd5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [3:0] req_op,
   input  logic [7:0] req_a,
   input  logic [7:0] req_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [7:0] rsp_wb,
   input  logic       flag_load,
   input  logic [3:0] flag_in,
   output logic [3:0] flags,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [4:0] alu_mode,
   output logic       alu_carry_in,
   input  logic [7:0] alu_out,
   input  logic       alu_carry_out,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_P1 = 2'd1, S_P2 = 2'd2, S_DONE = 2'd3} state_t;

   localparam logic [3:0] OP_ADC = 4'h0, OP_SBC = 4'h1, OP_AND = 4'h2, OP_ORA = 4'h3;
   localparam logic [3:0] OP_EOR = 4'h4, OP_CMP = 4'h5, OP_ASL = 4'h6, OP_LSR = 4'h7;
   localparam logic [3:0] OP_ROL = 4'h8, OP_ROR = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB;
   localparam logic [3:0] OP_BIT = 4'hC, OP_DCP = 4'hD, OP_ISC = 4'hE;

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [7:0] a_q, a_d, b_q, b_d;
   logic       c_q, c_d;          // carry captured at accept time
   logic [7:0] m_q, m_d;          // pass-1 result of the two-pass ops
   logic       mc_q, mc_d;        // pass-1 carry (used by RLA)
   logic [7:0] data_q, data_d, wb_q, wb_d;
   logic [3:0] flags_q, flags_d;  // {N,V,Z,C}

   logic n_r, z_r, v_r;

   assign flags     = flags_q;
   assign rsp_data  = data_q;
   assign rsp_wb    = wb_q;
   assign dbg_state = state_q;

   // ALU operand selection, driven purely from registered state
   always_comb begin
      alu_a        = 8'h00;
      alu_b        = 8'h00;
      alu_mode     = MODE_AND;
      alu_carry_in = 1'b0;
      if (state_q == S_P1) begin
         case (op_q)
            OP_ADC: begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = b_q;  alu_carry_in = c_q; end
            OP_SBC: begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = ~b_q; alu_carry_in = c_q; end
            OP_AND: begin alu_mode = MODE_AND; alu_a = a_q; alu_b = b_q; end
            OP_ORA: begin alu_mode = MODE_OR;  alu_a = a_q; alu_b = b_q; end
            OP_EOR: begin alu_mode = MODE_EOR; alu_a = a_q; alu_b = b_q; end
            OP_CMP: begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = ~b_q; alu_carry_in = 1'b1; end
            OP_ASL: begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = a_q; end
            OP_LSR: begin alu_mode = MODE_SR;  alu_a = a_q; end
            OP_ROL: begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = a_q;  alu_carry_in = c_q; end
            OP_ROR: begin alu_mode = MODE_SR;  alu_a = a_q; alu_carry_in = c_q; end
            OP_INC: begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = 8'h01; end
            OP_DEC: begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = 8'hFF; end
            OP_BIT: begin alu_mode = MODE_AND; alu_a = a_q; alu_b = b_q; end
            OP_DCP: begin alu_mode = MODE_ADD; alu_a = b_q; alu_b = 8'hFF; end
            OP_ISC: begin alu_mode = MODE_ADD; alu_a = b_q; alu_b = 8'h01; end
            default: begin alu_mode = MODE_ADD; alu_a = b_q; alu_b = b_q; alu_carry_in = c_q; end // RLA: ROL b
         endcase
      end else if (state_q == S_P2) begin
         case (op_q)
            OP_DCP:  begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = ~m_q; alu_carry_in = 1'b1; end
            OP_ISC:  begin alu_mode = MODE_ADD; alu_a = a_q; alu_b = ~m_q; alu_carry_in = c_q; end
            default: begin alu_mode = MODE_AND; alu_a = a_q; alu_b = m_q; end // RLA: a & m
         endcase
      end
   end

   // Next-state, handshake outputs and flag/result updates
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      c_d       = c_q;
      m_d       = m_q;
      mc_d      = mc_q;
      data_d    = data_q;
      wb_d      = wb_q;
      flags_d   = flags_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      n_r       = alu_out[7];
      z_r       = (alu_out == 8'h00);
      // Overflow from the operands actually driven, not from alu_carry_out
      v_r       = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
      case (state_q)
         S_IDLE: begin
            if (flag_load) begin
               flags_d = flag_in;   // flag_load has priority; no accept this cycle
            end else begin
               req_ready = 1'b1;
               if (req_valid) begin
                  op_d    = req_op;
                  a_d     = req_a;
                  b_d     = req_b;
                  c_d     = flags_q[0];
                  state_d = S_P1;
               end
            end
         end
         S_P1: begin
            if (op_q >= OP_DCP) begin
               m_d     = alu_out;
               mc_d    = alu_carry_out;
               state_d = S_P2;
            end else begin
               state_d = S_DONE;
               data_d  = ((op_q == OP_CMP) || (op_q == OP_BIT)) ? a_q : alu_out;
               wb_d    = ((op_q == OP_CMP) || (op_q == OP_BIT)) ? a_q : alu_out;
               case (op_q)
                  OP_ADC, OP_SBC:
                     flags_d = {n_r, v_r, z_r, alu_carry_out};
                  OP_CMP, OP_ASL, OP_LSR, OP_ROL, OP_ROR:
                     flags_d = {n_r, flags_q[2], z_r, alu_carry_out};
                  OP_BIT:
                     flags_d = {b_q[7], b_q[6], z_r, flags_q[0]};
                  default: // AND, ORA, EOR, INC, DEC
                     flags_d = {n_r, flags_q[2], z_r, flags_q[0]};
               endcase
            end
         end
         S_P2: begin
            state_d = S_DONE;
            wb_d    = m_q;
            case (op_q)
               OP_DCP: begin
                  data_d  = a_q;
                  flags_d = {n_r, flags_q[2], z_r, alu_carry_out};
               end
               OP_ISC: begin
                  data_d  = alu_out;
                  flags_d = {n_r, v_r, z_r, alu_carry_out};
               end
               default: begin // RLA: carry comes from the rotate pass
                  data_d  = alu_out;
                  flags_d = {n_r, flags_q[2], z_r, mc_q};
               end
            endcase
         end
         default: begin // S_DONE
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, async active-low reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         op_q    <= 4'h0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         c_q     <= 1'b0;
         m_q     <= 8'h00;
         mc_q    <= 1'b0;
         data_q  <= 8'h00;
         wb_q    <= 8'h00;
         flags_q <= 4'b0000;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         m_q     <= m_d;
         mc_q    <= mc_d;
         data_q  <= data_d;
         wb_q    <= wb_d;
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: behavioural ALU, reference model of the 6502
// operations, expected-result queue and directed + random stimulus.
module tb_alu_sequencer;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       req_valid, req_ready;
   logic [3:0] req_op;
   logic [7:0] req_a, req_b;
   logic       rsp_valid, rsp_ready;
   logic [7:0] rsp_data, rsp_wb;
   logic       flag_load;
   logic [3:0] flag_in, flags;
   logic [7:0] alu_a, alu_b;
   logic [4:0] alu_mode;
   logic       alu_carry_in;
   logic [7:0] alu_out;
   logic       alu_carry_out;
   logic [1:0] dbg_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic [19:0] exp_q[$];   // {rsp_data, rsp_wb, flags}
   logic [3:0]  tb_flags;   // bench's own view of N,V,Z,C

   // clock
   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_wb(rsp_wb),
      .flag_load(flag_load), .flag_in(flag_in), .flags(flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
      .alu_carry_in(alu_carry_in), .alu_out(alu_out),
      .alu_carry_out(alu_carry_out), .dbg_state(dbg_state)
   );

   // behavioural shared ALU
   logic [8:0] alu_sum;
   always_comb begin
      alu_sum       = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carry_in};
      alu_out       = 8'h00;
      alu_carry_out = 1'b0;
      case (alu_mode)
         5'd0: begin alu_out = alu_sum[7:0]; alu_carry_out = alu_sum[8]; end
         5'd2: alu_out = alu_a & alu_b;
         5'd3: alu_out = alu_a | alu_b;
         5'd4: alu_out = alu_a ^ alu_b;
         5'd5: begin alu_out = {alu_carry_in, alu_a[7:1]}; alu_carry_out = alu_a[0]; end
         default: alu_out = 8'h00;
      endcase
   end

   // reference model: returns {data, wb, N, V, Z, C}
   function automatic logic [19:0] model(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [3:0] f);
      logic n, v, z, c;
      logic [7:0] r, d, m, wb;
      int sum_s, sum_u;
      {n, v, z, c} = f;
      r = 8'h00; m = 8'h00;
      case (op)
         4'h0: begin
            sum_s = int'($signed(a)) + int'($signed(b)) + int'(c);
            sum_u = int'(a) + int'(b) + int'(c);
            r = 8'(sum_u); c = (sum_u > 255); v = (sum_s > 127) || (sum_s < -128);
         end
         4'h1, 4'hE: begin
            m = (op == 4'hE) ? b + 8'h01 : b;
            sum_s = int'($signed(a)) - int'($signed(m)) - (c ? 0 : 1);
            sum_u = int'(a) - int'(m) - (c ? 0 : 1);
            r = 8'(sum_u); c = (sum_u >= 0); v = (sum_s > 127) || (sum_s < -128);
         end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: begin r = a - b; c = (a >= b); end
         4'h6: begin r = a << 1; c = a[7]; end
         4'h7: begin r = a >> 1; c = a[0]; end
         4'h8: begin r = {a[6:0], c}; c = a[7]; end
         4'h9: begin r = {c, a[7:1]}; c = a[0]; end
         4'hA: r = a + 8'h01;
         4'hB: r = a - 8'h01;
         4'hC: r = a & b;
         4'hD: begin m = b - 8'h01; r = a - m; c = (a >= m); end
         default: begin m = {b[6:0], c}; c = b[7]; r = a & m; end
      endcase
      if (op == 4'hC) begin
         n = b[7]; v = b[6]; z = (r == 8'h00);
      end else begin
         n = r[7]; z = (r == 8'h00);
      end
      d  = (op == 4'h5 || op == 4'hC || op == 4'hD) ? a : r;
      wb = (op >= 4'hD) ? m : d;
      return {d, wb, n, v, z, c};
   endfunction

   // one comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // driver: load flags from flag_in while idle
   task automatic load_flags(input logic [3:0] v);
      flag_load = 1'b1; flag_in = v;
      @(posedge clk); #1;
      flag_load = 1'b0;
      tb_flags = v;
      chk("flag_load", 32'(flags), 32'(v));
   endtask

   // driver + scoreboard: issue one request, check latency and response,
   // optionally stall rsp_ready for 'hold' cycles with flag_load poked
   task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold);
      logic [19:0] e;
      int lat;
      e = model(op, a, b, tb_flags);
      exp_q.push_back(e);
      tb_flags  = e[3:0];
      req_op    = op; req_a = a; req_b = b; req_valid = 1'b1;
      @(posedge clk); #1;                      // accept edge counts as edge 1
      req_valid = 1'b0; req_a = 8'($urandom); req_b = 8'($urandom);
      lat = 1;
      while (!rsp_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("latency", 32'(lat), (op >= 4'hD) ? 32'd3 : 32'd2);
      e = exp_q.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(e[19:12]));
      chk("rsp_wb",   32'(rsp_wb),   32'(e[11:4]));
      chk("flags",    32'(flags),    32'(e[3:0]));
      if (hold > 0) begin
         flag_load = 1'b1; flag_in = 4'b1111;
         repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_ready", 32'(req_ready), 32'd0);
            chk("hold_data",  32'(rsp_data),  32'(e[19:12]));
            chk("hold_wb",    32'(rsp_wb),    32'(e[11:4]));
            chk("hold_flags", 32'(flags),     32'(e[3:0]));
         end
         flag_load = 1'b0;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop",  32'(rsp_valid), 32'd0);
      chk("req_ready", 32'(req_ready), 32'd1);
   endtask

   initial begin
      // reset
      reset_n = 1'b0; req_valid = 1'b0; req_op = 4'h0; req_a = 8'h00; req_b = 8'h00;
      rsp_ready = 1'b0; flag_load = 1'b0; flag_in = 4'h0; tb_flags = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data",  32'(rsp_data),  32'd0);
      chk("rst_wb",    32'(rsp_wb),    32'd0);
      chk("rst_flags", 32'(flags),     32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_mode",  32'(alu_mode),  32'd2);
      chk("rst_alu_a", 32'(alu_a),     32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // directed operations with hand-derived expectations cross-checked
      run_op(4'h0, 8'h50, 8'h50, 0);  // ADC -> A0, NV
      chk("plan_adc1", 32'(flags), 32'b1100);
      run_op(4'h0, 8'h80, 8'h80, 0);  // ADC -> 00, VZC
      chk("plan_adc2", 32'({rsp_data, flags}), 32'h007);
      run_op(4'h5, 8'h10, 8'h10, 0);  // CMP equal, V kept
      chk("plan_cmp1", 32'({rsp_data, flags}), 32'h107);
      run_op(4'h5, 8'h10, 8'h20, 0);  // CMP less
      chk("plan_cmp2", 32'(flags), 32'b1100);
      load_flags(4'b0001);
      run_op(4'h9, 8'h01, 8'h00, 0);  // ROR with C=1 -> 80
      chk("plan_ror", 32'({rsp_data, flags}), 32'h809);
      run_op(4'h7, 8'h01, 8'h00, 0);  // LSR -> 00, Z C
      chk("plan_lsr", 32'({rsp_data, flags}), 32'h003);
      run_op(4'hD, 8'h05, 8'h06, 0);  // DCP
      chk("plan_dcp", 32'({rsp_data, rsp_wb, flags}), 32'h05053);
      run_op(4'hE, 8'h10, 8'h0F, 0);  // ISC with C=1
      chk("plan_isc", 32'({rsp_data, rsp_wb, flags}), 32'h00103);
      run_op(4'hC, 8'h0F, 8'hC0, 0);  // BIT -> N V Z set, C kept
      chk("plan_bit", 32'({rsp_data, flags}), 32'h0FF);
      load_flags(4'b0000);
      run_op(4'hF, 8'h0F, 8'h81, 0);  // RLA: m=02, C from b[7]
      chk("plan_rla", 32'({rsp_data, rsp_wb, flags}), 32'h02021);

      // stalled response with flag_load poked while busy
      run_op(4'h0, 8'h01, 8'h02, 4);

      // flag_load beats a simultaneous request in IDLE
      req_valid = 1'b1; req_op = 4'h2; flag_load = 1'b1; flag_in = 4'b1010;
      #1;
      chk("fl_wins_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0; flag_load = 1'b0;
      chk("fl_wins_flags", 32'(flags), 32'b1010);
      chk("fl_wins_state", 32'(dbg_state), 32'd0);
      tb_flags = 4'b1010;

      // reset while in P2 drops the in-flight two-pass op
      req_op = 4'hD; req_a = 8'h33; req_b = 8'h44; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("in_p2", 32'(dbg_state), 32'd2);
      reset_n = 1'b0;
      #2;
      chk("arst_state", 32'(dbg_state), 32'd0);
      chk("arst_flags", 32'(flags),     32'd0);
      chk("arst_valid", 32'(rsp_valid), 32'd0);
      chk("arst_wb",    32'(rsp_wb),    32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      tb_flags = 4'h0;
      @(posedge clk); #1;

      // random operations against the model
      for (int i = 0; i < 24; i++) begin
         load_flags(4'($urandom_range(0, 15)));
         run_op(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), (i % 8 == 0) ? 2 : 0);
      end

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
